adder_share_ctrl: RTL and testbench

- Sequencer/arbiter that time-shares one slow, gate-level, combinational 32-bit adder (Cin in, Cout out) between N_REQ requesters.
- Arbitrates round-robin, registers the winner's operands onto the adder inputs, and waits a programmable settle time.
- Captures {Cout,S} and returns the result to the winner with a one-cycle done pulse.
- Sits between the datapath clients and the Adder_32bit_nlogic instance.

---
 rtl/adder_share_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_adder_share_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_ctrl.sv
// Round-robin sequencer that time-shares one slow combinational adder between N_REQ clients.
// Optional macro ADDER_CHECK_EN adds a behavioural reference sum and a sticky mismatch flag.
module adder_share_ctrl #(
  parameter int N_REQ      = 4,
  parameter int WIDTH      = 32,
  parameter int SETTLE_CYC = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_in,
  input  logic [N_REQ*WIDTH-1:0] b_in,
  input  logic [N_REQ-1:0]       cin_in,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic [WIDTH-1:0]       sum_out,
  output logic                   cout_out,
  output logic                   busy,
  output logic [WIDTH-1:0]       add_a,
  output logic [WIDTH-1:0]       add_b,
  output logic                   add_cin,
  input  logic [WIDTH-1:0]       add_s,
  input  logic                   add_cout,
  output logic                   chk_err
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [IW-1:0]     r_rr_ptr;
  logic [IW-1:0]     r_win;
  logic [CW-1:0]     r_cnt;
  logic [N_REQ-1:0]  r_gnt;
  logic [N_REQ-1:0]  r_done;
  logic [WIDTH-1:0]  r_sum;
  logic              r_cout;
  logic [WIDTH-1:0]  r_add_a;
  logic [WIDTH-1:0]  r_add_b;
  logic              r_add_cin;

  logic              w_found;
  logic [IW-1:0]     w_win;
  int                w_idx;
  logic              w_grant;
  logic              w_capture;
  logic [N_REQ-1:0]  w_win_oh;
  logic [N_REQ-1:0]  w_held_oh;
  logic [WIDTH-1:0]  w_a_arr [N_REQ];
  logic [WIDTH-1:0]  w_b_arr [N_REQ];
  logic [WIDTH-1:0]  w_sel_a;
  logic [WIDTH-1:0]  w_sel_b;
  logic              w_sel_cin;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign w_a_arr[gi]   = a_in[gi*WIDTH +: WIDTH];
      assign w_b_arr[gi]   = b_in[gi*WIDTH +: WIDTH];
      assign w_win_oh[gi]  = (w_win == IW'(gi));
      assign w_held_oh[gi] = (r_win == IW'(gi));
    end
  endgenerate

  assign w_sel_a   = w_a_arr[w_win];
  assign w_sel_b   = w_b_arr[w_win];
  assign w_sel_cin = cin_in[w_win];

  // Scan from the highest rotation offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      if (req[IW'(w_idx)]) begin
        w_found = 1'b1;
        w_win   = IW'(w_idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant      = 1'b1;
          w_state_next = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_cnt == '0) begin
          w_capture    = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr  <= '0;
      r_win     <= '0;
      r_cnt     <= '0;
      r_gnt     <= '0;
      r_done    <= '0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
      r_add_a   <= '0;
      r_add_b   <= '0;
      r_add_cin <= 1'b0;
    end else begin
      r_gnt  <= '0;
      r_done <= '0;
      if (w_grant) begin
        r_win     <= w_win;
        r_add_a   <= w_sel_a;
        r_add_b   <= w_sel_b;
        r_add_cin <= w_sel_cin;
        r_gnt     <= w_win_oh;
        r_cnt     <= CW'(SETTLE_CYC - 1);
      end
      if (r_state == S_SETTLE && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      if (w_capture) begin
        r_sum  <= add_s;
        r_cout <= add_cout;
        r_done <= w_held_oh;
      end
      if (r_state == S_DONE)
        r_rr_ptr <= (r_win == IW'(N_REQ - 1)) ? '0 : r_win + 1'b1;
    end
  end

`ifdef ADDER_CHECK_EN
  logic [WIDTH:0] r_ref;
  logic           r_chk_err;

  // Reference is taken from the same operands latched onto the adder, so it tracks the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref     <= '0;
      r_chk_err <= 1'b0;
    end else begin
      if (w_grant)
        r_ref <= {1'b0, w_sel_a} + {1'b0, w_sel_b} + {{WIDTH{1'b0}}, w_sel_cin};
      if (w_capture && ({add_cout, add_s} != r_ref))
        r_chk_err <= 1'b1;
    end
  end

  assign chk_err = r_chk_err;
`else
  assign chk_err = 1'b0;
`endif

  assign gnt      = r_gnt;
  assign done     = r_done;
  assign sum_out  = r_sum;
  assign cout_out = r_cout;
  assign busy     = (r_state != S_IDLE);
  assign add_a    = r_add_a;
  assign add_b    = r_add_b;
  assign add_cin  = r_add_cin;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed bench for adder_share_ctrl: behavioural adder, expected-result queue, immediate-assert checks.
module tb_adder_share_ctrl;
  localparam int N = 4;
  localparam int W = 32;
  localparam int S = 4;

  typedef struct {
    int          idx;
    logic [W-1:0] sum;
    logic        cout;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] a_in = '0;
  logic [N*W-1:0] b_in = '0;
  logic [N-1:0]   cin_in = '0;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic [W-1:0]   sum_out;
  logic           cout_out;
  logic           busy;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic           add_cin;
  logic [W-1:0]   add_s;
  logic           add_cout;
  logic           chk_err;

  logic           fault = 1'b0;
  logic [W:0]     true_sum;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   gnt_cyc = 0;
  int   prev_gnt_cyc = 0;
  exp_t sb[$];
  int   order[5] = '{0, 1, 2, 3, 0};

  adder_share_ctrl #(.N_REQ(N), .WIDTH(W), .SETTLE_CYC(S)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
    .gnt(gnt), .done(done), .sum_out(sum_out), .cout_out(cout_out), .busy(busy),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout),
    .chk_err(chk_err)
  );

  // Adder model; fault forces sum bit 5 stuck-at-0.
  assign true_sum = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
  assign add_s    = true_sum[W-1:0] & ~(fault ? 32'h0000_0020 : 32'h0);
  assign add_cout = true_sum[W];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
    cin_in[i]      = c;
  endtask

  function automatic exp_t model(input int i);
    exp_t       e;
    logic [W:0] s;
    s = {1'b0, a_in[i*W +: W]} + {1'b0, b_in[i*W +: W]} + {{W{1'b0}}, cin_in[i]};
    if (fault) s[5] = 1'b0;
    e.idx  = i;
    e.sum  = s[W-1:0];
    e.cout = s[W];
    return e;
  endfunction

  task automatic wait_gnt(input int exp_idx);
    int n;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (gnt != '0) break;
    end
    check("gnt_seen", {63'd0, gnt != '0}, 64'd1);
    check("gnt_onehot", {60'd0, gnt}, 64'd1 << exp_idx);
    prev_gnt_cyc = gnt_cyc;
    gnt_cyc = cyc;
  endtask

  task automatic wait_done();
    int   n;
    exp_t e;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (done != '0) break;
    end
    check("done_latency", 64'(n), 64'(S));
    if (sb.size() == 0) begin
      check("sb_nonempty", 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check("done_onehot", {60'd0, done}, 64'd1 << e.idx);
      check("sum_out", {32'd0, sum_out}, {32'd0, e.sum});
      check("cout_out", {63'd0, cout_out}, {63'd0, e.cout});
      $display("txn idx=%0d sum=%0h cout=%0b (exp sum=%0h cout=%0b) cyc=%0d",
               e.idx, sum_out, cout_out, e.sum, e.cout, cyc);
    end
  endtask

  task automatic run_op(input logic [N-1:0] mask, input int exp_idx);
    sb.push_back(model(exp_idx));
    req = mask;
    wait_gnt(exp_idx);
    req = '0;
    wait_done();
  endtask

  initial begin
    set_op(0, 32'h0000_1000, 32'h0000_0234, 1'b0);
    set_op(1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
    set_op(2, 32'h8000_0000, 32'h8000_0000, 1'b1);
    set_op(3, 32'h1234_5678, 32'h1111_1111, 1'b0);
    #2;
    check("rst_gnt", {60'd0, gnt}, 64'd0);
    check("rst_busy_sum", {31'd0, busy, sum_out}, 64'd0);
    check("rst_add", {add_cin, add_a, add_b}, 64'd0);
    check("rst_chk_err", {63'd0, chk_err}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Contention: all requesting, grants must rotate with fixed spacing.
    for (int k = 0; k < 5; k++) sb.push_back(model(order[k]));
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(order[k]);
      if (k > 0) check("gnt_spacing", 64'(gnt_cyc - prev_gnt_cyc), 64'(S + 2));
      if (k == 4) req = '0;
      wait_done();
    end

    set_op(2, 32'd65530, 32'd65535, 1'b1);
    run_op(4'b0100, 2);
    set_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_op(4'b0001, 0);
    set_op(1, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1);
    run_op(4'b0010, 1);
    repeat (3) @(negedge clk);
    check("sum_hold", {31'd0, cout_out, sum_out}, {31'd0, 1'b1, 32'h1});

    set_op(0, 32'h0000_00AA, 32'h0000_0055, 1'b1);
    run_op(4'b0011, 0);
    set_op(2, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    run_op(4'b0101, 2);

`ifdef ADDER_CHECK_EN
    fault = 1'b1;
    set_op(3, 32'd32, 32'd0, 1'b0);
    run_op(4'b1000, 3);
    fault = 1'b0;
    check("chk_err_set", {63'd0, chk_err}, 64'd1);
    set_op(0, 32'd5, 32'd6, 1'b0);
    run_op(4'b0001, 0);
    check("chk_err_sticky", {63'd0, chk_err}, 64'd1);
`else
    check("chk_err_off", {63'd0, chk_err}, 64'd0);
`endif

    // Reset in the middle of an operation on requester 3.
    set_op(3, 32'h0BAD_F00D, 32'h1, 1'b1);
    set_op(1, 32'd100, 32'd23, 1'b0);
    req = 4'b1000;
    wait_gnt(3);
    req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_gnt_done", {56'd0, gnt, done}, 64'd0);
    check("mid_rst_sum", {30'd0, busy, cout_out, sum_out}, 64'd0);
    check("mid_rst_add", {add_cin, add_a, add_b}, 64'd0);
    check("mid_rst_chk_err", {63'd0, chk_err}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (done != '0 || busy) seen++;
      end
      check("no_done_after_rst", 64'(seen), 64'd0);
    end
    run_op(4'b0110, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
